// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg: shared reset/enable levels, bus widths and fetch FSM state encoding
package if_fetch_ctrl_pkg;
  localparam logic RstEnable = 1'b0;
  localparam logic RstDisable = 1'b1;
  localparam logic ChipEnable = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam int InstAddrBus = 32;
  localparam int InstBus = 32;
  typedef enum logic [1:0] {IF_IDLE, IF_FETCH, IF_WAIT, IF_DRAIN} if_state_e;
endpackage

// File: rtl/if_fetch_ctrl_buf.sv
// fetch_buf: 2-entry {pc,inst} FIFO with push, pop, clear, count and combinational head
// ports: clk, rst (active-low sync), i_push/i_pc/i_inst write side, i_pop, i_clear (overrides push/pop),
//        o_count occupancy, o_pc/o_inst head entry
module fetch_buf
  import if_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int DATA_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_inst,
  output logic [1:0]        o_count,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_inst
);
  logic [ADDR_W-1:0] r_pc [2];
  logic [DATA_W-1:0] r_inst [2];
  logic              r_rd;
  logic              r_wr;
  logic [1:0]        r_count;
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_pc    <= '{default: '0};
      r_inst  <= '{default: '0};
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else if (i_clear) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_pc[r_wr]   <= i_pc;
        r_inst[r_wr] <= i_inst;
        r_wr         <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
  always_ff @(posedge clk) begin
    if (rst != RstEnable && !i_clear) assert (!(i_push && r_count == 2'd2));
  end
  assign o_count = r_count;
  assign o_pc    = r_pc[r_rd];
  assign o_inst  = r_inst[r_rd];
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: sequences fetch PCs over an imem req/ack handshake into a 2-entry decode buffer
// ports: clk, rst (active-low sync); flush_i/new_pc_i redirect; imem_ce_o/imem_req_o/imem_addr_o,
//        imem_ack_i/imem_rdata_i memory side; inst_valid_o/inst_o/inst_pc_o/inst_ready_i decode side
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int              ADDR_W   = InstAddrBus,
  parameter int              DATA_W   = InstBus,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic              imem_ce_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);
  if_state_e         r_state;
  logic              r_ce;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        w_count;
  logic              w_pop;
  logic              w_push;
  logic              w_stall;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_next_pc;
  assign w_tgt     = {new_pc_i[ADDR_W-1:2], 2'b00};
  assign w_pc_inc  = r_pc + ADDR_W'(4);
  assign w_next_pc = flush_i ? w_tgt : r_pc;
  assign w_pop     = inst_valid_o && inst_ready_i;
  assign w_push    = r_state == IF_FETCH && imem_ack_i && !flush_i;
  // FETCH always runs with count<2, so only a push onto one entry without a pop fills the buffer
  assign w_stall   = w_count == 2'd1 && !w_pop;
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state <= IF_IDLE;
      r_ce    <= ChipDisable;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_pc    <= RESET_PC;
    end else if (r_state == IF_IDLE) begin
      r_state <= IF_FETCH;
      r_ce    <= ChipEnable;
      r_req   <= 1'b1;
      r_pc    <= w_next_pc;
      r_addr  <= w_next_pc;
    end else if (flush_i && r_req && !imem_ack_i) begin
      // outstanding request must finish at its old address; only the target moves
      r_state <= IF_DRAIN;
      r_pc    <= w_tgt;
    end else if (flush_i || (r_state == IF_DRAIN && imem_ack_i)) begin
      r_state <= IF_FETCH;
      r_req   <= 1'b1;
      r_pc    <= w_next_pc;
      r_addr  <= w_next_pc;
    end else if (r_state == IF_FETCH && imem_ack_i) begin
      r_state <= w_stall ? IF_WAIT : IF_FETCH;
      r_req   <= !w_stall;
      r_pc    <= w_pc_inc;
      r_addr  <= w_pc_inc;
    end else if (r_state == IF_WAIT && w_pop) begin
      r_state <= IF_FETCH;
      r_req   <= 1'b1;
    end
  end
  fetch_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop && !flush_i),
    .i_clear (flush_i),
    .i_pc    (r_pc),
    .i_inst  (imem_rdata_i),
    .o_count (w_count),
    .o_pc    (inst_pc_o),
    .o_inst  (inst_o)
  );
  assign inst_valid_o = w_count != 2'd0;
  assign imem_ce_o    = r_ce;
  assign imem_req_o   = r_req;
  assign imem_addr_o  = r_addr;
endmodule
